// File: rtl/dice_race_move_fsm.sv
// Turn/move controller for the dice race game: arms on a roll request, waits for the colour result, animates the token steps, then detects the winner or rotates the turn.
// Optional macro DICE_RACE_EXACT_FINISH_EN: an overshoot bounces back from the goal, so a win needs an exact landing.
module dice_race_move_fsm #(
    parameter int NUM_PLAYERS  = 2,
    parameter int TRACK_LEN    = 16,
    parameter int STEP_TICKS   = 25000000,
    parameter int WAIT_TIMEOUT = 100000000
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          new_game,
    input  logic                                          roll_req,
    input  logic                                          result_ready,
    input  logic [1:0]                                    movement_steps,
    output logic [NUM_PLAYERS*$clog2(TRACK_LEN+1)-1:0]    player_pos,
    output logic [1:0]                                    cur_player,
    output logic                                          busy,
    output logic                                          step_pulse,
    output logic                                          roll_timeout,
    output logic                                          winner_valid,
    output logic [1:0]                                    winner_id
);

    localparam int POS_W  = $clog2(TRACK_LEN + 1);
    localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int TO_W   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    localparam logic [POS_W-1:0]  GOAL        = POS_W'(TRACK_LEN);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(STEP_TICKS - 1);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(WAIT_TIMEOUT - 1);
    localparam logic [1:0]        LAST_PLAYER = 2'(NUM_PLAYERS - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_RESULT = 3'd1;
    localparam logic [2:0] S_MOVE        = 3'd2;
    localparam logic [2:0] S_CHECK       = 3'd3;
    localparam logic [2:0] S_WIN         = 3'd4;

    logic [2:0]                     state;
    logic [NUM_PLAYERS*POS_W-1:0]   pos_q;
    logic [1:0]                     player_q;
    logic [1:0]                     winner_q;
    logic [1:0]                     rem_q;
    logic [TICK_W-1:0]              tick_cnt;
    logic [TO_W-1:0]                to_cnt;
    logic                           step_q;
    logic                           timeout_q;
    logic [POS_W-1:0]               cur_pos;
    logic [POS_W-1:0]               step_pos;
`ifdef DICE_RACE_EXACT_FINISH_EN
    logic                           bounce_q;
`endif

    // Active player's square and where one animated step takes it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cur_pos = '0;
        for (int k = 0; k < NUM_PLAYERS; k++) begin
            if (player_q == 2'(k)) begin
                cur_pos = pos_q[k*POS_W +: POS_W];
            end
        end
        step_pos = cur_pos;
`ifdef DICE_RACE_EXACT_FINISH_EN
        if (bounce_q || cur_pos == GOAL) begin
            if (cur_pos != '0) begin
                step_pos = cur_pos - POS_W'(1);
            end
        end else begin
            step_pos = cur_pos + POS_W'(1);
        end
`else
        if (cur_pos != GOAL) begin
            step_pos = cur_pos + POS_W'(1);
        end
`endif
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pos_q     <= '0;
            player_q  <= '0;
            winner_q  <= '0;
            rem_q     <= '0;
            tick_cnt  <= '0;
            to_cnt    <= '0;
            step_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef DICE_RACE_EXACT_FINISH_EN
            bounce_q  <= 1'b0;
`endif
        end else begin
            step_q    <= 1'b0;
            timeout_q <= 1'b0;
            if (new_game) begin
                state    <= S_IDLE;
                pos_q    <= '0;
                player_q <= '0;
                winner_q <= '0;
                rem_q    <= '0;
                tick_cnt <= '0;
                to_cnt   <= '0;
`ifdef DICE_RACE_EXACT_FINISH_EN
                bounce_q <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (roll_req) begin
                            to_cnt <= '0;
                            state  <= S_WAIT_RESULT;
                        end
                    end
                    S_WAIT_RESULT: begin
                        // A valid result beats a timeout landing in the same cycle.
                        if (result_ready && movement_steps != 2'd0) begin
                            rem_q    <= movement_steps;
                            tick_cnt <= '0;
`ifdef DICE_RACE_EXACT_FINISH_EN
                            bounce_q <= 1'b0;
`endif
                            state    <= S_MOVE;
                        end else if (to_cnt == TO_LAST) begin
                            timeout_q <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    S_MOVE: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            step_q   <= 1'b1;
                            rem_q    <= rem_q - 2'd1;
                            for (int k = 0; k < NUM_PLAYERS; k++) begin
                                if (player_q == 2'(k)) begin
                                    pos_q[k*POS_W +: POS_W] <= step_pos;
                                end
                            end
`ifdef DICE_RACE_EXACT_FINISH_EN
                            if (cur_pos == GOAL) begin
                                bounce_q <= 1'b1;
                            end
`endif
                            if (rem_q == 2'd1) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                    S_CHECK: begin
                        if (cur_pos == GOAL) begin
                            winner_q <= player_q;
                            state    <= S_WIN;
                        end else begin
                            player_q <= (player_q == LAST_PLAYER) ? 2'd0 : player_q + 2'd1;
                            state    <= S_IDLE;
                        end
                    end
                    S_WIN: begin
                        state <= S_WIN;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign player_pos   = pos_q;
    assign cur_player   = player_q;
    assign busy         = (state == S_WAIT_RESULT) || (state == S_MOVE);
    assign step_pulse   = step_q;
    assign roll_timeout = timeout_q;
    assign winner_valid = (state == S_WIN);
    assign winner_id    = winner_q;

endmodule

// File: tb/tb_dice_race_move_fsm.sv
// Self-checking bench for dice_race_move_fsm: directed and randomized turns against a square-count reference model.
module tb_dice_race_move_fsm;

    localparam int NP = 2;
    localparam int TL = 16;
    localparam int ST = 4;
    localparam int WT = 20;
    localparam int PW = $clog2(TL + 1);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            new_game = 1'b0;
    logic            roll_req = 1'b0;
    logic            result_ready = 1'b0;
    logic [1:0]      movement_steps = 2'd0;
    logic [NP*PW-1:0] player_pos;
    logic [1:0]      cur_player;
    logic            busy;
    logic            step_pulse;
    logic            roll_timeout;
    logic            winner_valid;
    logic [1:0]      winner_id;

    int vectors = 0;
    int miscompares = 0;
    int model_pos[NP];
    int model_player = 0;

    dice_race_move_fsm #(
        .NUM_PLAYERS(NP), .TRACK_LEN(TL), .STEP_TICKS(ST), .WAIT_TIMEOUT(WT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game), .roll_req(roll_req),
        .result_ready(result_ready), .movement_steps(movement_steps),
        .player_pos(player_pos), .cur_player(cur_player), .busy(busy),
        .step_pulse(step_pulse), .roll_timeout(roll_timeout),
        .winner_valid(winner_valid), .winner_id(winner_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int get_pos(input int k);
        return int'(player_pos[k*PW +: PW]);
    endfunction

    // Square reached after k of the rolled steps, starting from 'start'.
    function automatic int model_after(input int start, input int k);
        int p = start + k;
`ifdef DICE_RACE_EXACT_FINISH_EN
        if (p > TL) p = 2 * TL - p;
`else
        if (p > TL) p = TL;
`endif
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NP; k++) model_pos[k] = 0;
        model_player = 0;
    endtask

    task automatic check_board(input string tag);
        for (int k = 0; k < NP; k++) check({tag, "_pos"}, get_pos(k), model_pos[k]);
        check({tag, "_player"}, cur_player, model_player);
    endtask

    // One full turn: roll, optional idle/zero-step results, accepted result, animated steps, CHECK.
    task automatic do_turn(input int n, input bit zero_first, input bit noise, input int wait_cycles);
        int pl = model_player;
        int start = model_pos[pl];
        int noise_cyc = $urandom_range(1, n * ST - 1);
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        check("wait_busy", busy, 1);
        for (int w = 0; w < wait_cycles; w++) begin
            if (zero_first && w == 0) begin
                result_ready = 1'b1;
                movement_steps = 2'd0;
            end
            roll_req = (w == 1);
            tick();
            result_ready = 1'b0;
            roll_req = 1'b0;
            check("wait_hold", busy, 1);
            check("wait_no_timeout", roll_timeout, 0);
        end
        result_ready = 1'b1;
        movement_steps = 2'(n);
        tick();
        result_ready = 1'b0;
        movement_steps = 2'd0;
        check("accept_no_timeout", roll_timeout, 0);
        for (int c = 1; c <= n * ST; c++) begin
            if (noise && c == noise_cyc) begin
                roll_req = 1'b1;
                result_ready = 1'b1;
                movement_steps = 2'($urandom_range(1, 3));
            end
            tick();
            roll_req = 1'b0;
            result_ready = 1'b0;
            movement_steps = 2'd0;
            check("step_pulse", step_pulse, (c % ST == 0));
            check("busy_move", busy, (c < n * ST));
            if (c % ST == 0) check("step_pos", get_pos(pl), model_after(start, c / ST));
        end
        model_pos[pl] = model_after(start, n);
        tick();
        if (model_pos[pl] == TL) begin
            check("win_valid", winner_valid, 1);
            check("win_id", winner_id, pl);
        end else begin
            model_player = (pl + 1) % NP;
            check("no_win", winner_valid, 0);
        end
        check("turn_busy", busy, 0);
        check_board("turn");
    endtask

    initial begin
        model_clear();
        // Reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_board("reset");
        check("reset_busy", busy, 0);
        check("reset_step", step_pulse, 0);
        check("reset_timeout", roll_timeout, 0);
        check("reset_winv", winner_valid, 0);
        check("reset_winid", winner_id, 0);

        // result_ready is ignored in IDLE
        result_ready = 1'b1;
        movement_steps = 2'd3;
        tick();
        result_ready = 1'b0;
        movement_steps = 2'd0;
        for (int c = 0; c < 2 * ST; c++) begin
            tick();
            check("idle_ignore_step", step_pulse, 0);
        end
        check("idle_ignore_busy", busy, 0);
        check_board("idle_ignore");

        // Two steps for player 0
        do_turn(2, 1'b0, 1'b0, 0);

        // Timeout: same player keeps the turn
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        for (int c = 1; c < WT; c++) begin
            tick();
            check("to_early", roll_timeout, 0);
        end
        tick();
        check("to_pulse", roll_timeout, 1);
        check("to_busy", busy, 0);
        tick();
        check("to_single", roll_timeout, 0);
        check_board("timeout");

        // Zero-step result ignored, then three steps
        do_turn(3, 1'b1, 1'b0, 2);
        // Valid result in the timeout cycle wins
        do_turn(1, 1'b0, 1'b0, WT - 1);
        // Inputs during MOVE are ignored
        do_turn(2, 1'b0, 1'b1, 1);

        for (int t = 0; t < 6; t++) begin
            do_turn($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(1, 10));
        end

        // new_game mid-MOVE
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        result_ready = 1'b1;
        movement_steps = 2'd3;
        tick();
        result_ready = 1'b0;
        movement_steps = 2'd0;
        repeat (ST + 1) tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        check_board("newgame");
        check("newgame_busy", busy, 0);
        check("newgame_step", step_pulse, 0);
        for (int c = 0; c < 3 * ST; c++) begin
            tick();
            check("newgame_quiet", step_pulse, 0);
        end

        // reset_n mid-MOVE, observed before the next clock edge
        do_turn(2, 1'b0, 1'b0, 0);
        roll_req = 1'b1;
        tick();
        roll_req = 1'b0;
        result_ready = 1'b1;
        movement_steps = 2'd3;
        tick();
        result_ready = 1'b0;
        movement_steps = 2'd0;
        repeat (ST) tick();
        #1 reset_n = 1'b0;
        #1;
        model_clear();
        check_board("async_reset");
        check("async_reset_busy", busy, 0);
        check("async_reset_step", step_pulse, 0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 3 * ST; c++) begin
            tick();
            check("reset_quiet", step_pulse, 0);
        end

        // Drive player 0 to square 15, then roll 3
        for (int r = 0; r < 5; r++) begin
            do_turn(3, 1'b0, 1'b0, 0);
            do_turn(1, 1'b0, 1'b0, 0);
        end
        check("pre_win_pos", get_pos(0), 15);
        do_turn(3, 1'b0, 1'b0, 0);
        if (model_pos[0] == TL) begin
            roll_req = 1'b1;
            tick();
            roll_req = 1'b0;
            repeat (2 * ST) tick();
            check("win_hold", winner_valid, 1);
            check("win_hold_busy", busy, 0);
            check_board("win_hold");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
